// File: rtl/muldiv_unit_pkg.sv
// Shared control encodings for the execute-stage multiply/divide unit:
// operation codes, FSM states and small operand helpers.
package muldiv_unit_pkg;

   typedef enum logic [2:0] {
      MD_NOP   = 3'b000,
      MD_MULT  = 3'b001,
      MD_MULTU = 3'b010,
      MD_DIV   = 3'b011,
      MD_DIVU  = 3'b100,
      MD_MTHI  = 3'b101,
      MD_MTLO  = 3'b110
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10
   } md_state_e;

   localparam int MD_CNT_W = 5;

   function automatic logic is_muldiv(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic is_signed_op(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the mul/div unit.
interface muldiv_unit_if #(parameter int WIDTH = 32);

   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, op, A, B, input busy, done, hi, lo);
   modport slave  (input start, op, A, B, output busy, done, hi, lo);

endinterface

// File: rtl/muldiv_unit_md_iter_core.sv
// Iteration datapath: one shift-add (multiply) or restoring-subtract (divide)
// step per enabled edge on unsigned magnitudes.
module md_iter_core #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               step,
   input  logic               is_div,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   output logic [2*WIDTH-1:0] acc,
   output logic [WIDTH-1:0]   quo
);

   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   shreg;
   logic [WIDTH-1:0]   opb;

   logic [2*WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0]   sh_nxt;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH+1:0]   trial;
   logic               qbit;

   // Multiply consumes the multiplier MSB-first so the accumulator only ever
   // shifts left; divide reuses shreg to shift dividend bits out and quotient
   // bits in.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      acc_nxt = acc_q;
      sh_nxt  = shreg;
      rem_sh  = {acc_q[WIDTH-1:0], shreg[WIDTH-1]};
      trial   = {1'b0, rem_sh} - {2'b00, opb};
      qbit    = ~trial[WIDTH+1];
      if (is_div) begin
         acc_nxt = {{(WIDTH-1){1'b0}}, (qbit ? trial[WIDTH:0] : rem_sh)};
         sh_nxt  = {shreg[WIDTH-2:0], qbit};
      end else begin
         acc_nxt = {acc_q[2*WIDTH-2:0], 1'b0}
                 + (shreg[WIDTH-1] ? {{WIDTH{1'b0}}, opb} : {(2*WIDTH){1'b0}});
         sh_nxt  = {shreg[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         shreg <= '0;
         opb   <= '0;
      end else if (load) begin
         acc_q <= '0;
         shreg <= a_in;
         opb   <= b_in;
      end else if (step) begin
         acc_q <= acc_nxt;
         shreg <= sh_nxt;
      end
   end

   assign acc = acc_q;
   assign quo = shreg;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers;
// holds the sequencing FSM, iteration counter, HI/LO and sign correction.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int          WIDTH  = 32,
   parameter logic [31:0] DIV0_Q = 32'hFFFF_FFFF
) (
   input  logic           clk,
   input  logic           rst,
   muldiv_unit_if.slave   bus
);

   md_state_e           state;
   logic [MD_CNT_W-1:0] cnt;
   logic                busy_q;
   logic                done_q;
   logic [WIDTH-1:0]    hi_q;
   logic [WIDTH-1:0]    lo_q;

   logic                div_q;
   logic                neg_a;
   logic                neg_b;
   logic                div0;
   logic [WIDTH-1:0]    orig_a;

   logic                accept;
   logic                op_signed;
   logic [WIDTH-1:0]    mag_a;
   logic [WIDTH-1:0]    mag_b;
   logic [2*WIDTH-1:0]  core_acc;
   logic [WIDTH-1:0]    core_quo;
   logic                neg_res;
   logic [2*WIDTH-1:0]  prod_fix;
   logic [WIDTH-1:0]    quo_fix;
   logic [WIDTH-1:0]    rem_fix;

   assign accept    = (state == IDLE) && bus.start && is_muldiv(bus.op);
   assign op_signed = is_signed_op(bus.op);
   assign mag_a     = op_signed ? abs32(bus.A) : bus.A;
   assign mag_b     = op_signed ? abs32(bus.B) : bus.B;

   md_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk    (clk),
      .rst    (rst),
      .load   (accept),
      .step   (state == CALC),
      .is_div (div_q),
      .a_in   (mag_a),
      .b_in   (mag_b),
      .acc    (core_acc),
      .quo    (core_quo)
   );

   // Sign flags are zero for unsigned ops, so one correction path serves both.
   // The remainder takes the dividend's sign; 0x8000_0000 / -1 falls out here.
   assign neg_res  = neg_a ^ neg_b;
   assign prod_fix = neg_res ? (~core_acc + 64'd1) : core_acc;
   assign quo_fix  = neg_res ? (~core_quo + 32'd1) : core_quo;
   assign rem_fix  = neg_a ? (~core_acc[WIDTH-1:0] + 32'd1) : core_acc[WIDTH-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
         div_q  <= 1'b0;
         neg_a  <= 1'b0;
         neg_b  <= 1'b0;
         div0   <= 1'b0;
         orig_a <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignment so every branch
         // reads pre-edge values, independent of statement order.
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  state  <= CALC;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  div_q  <= is_div_op(bus.op);
                  neg_a  <= op_signed & bus.A[WIDTH-1];
                  neg_b  <= op_signed & bus.B[WIDTH-1];
                  div0   <= (bus.B == '0);
                  orig_a <= bus.A;
               end else if (bus.start && (bus.op == MD_MTHI)) begin
                  hi_q <= bus.A;
               end else if (bus.start && (bus.op == MD_MTLO)) begin
                  lo_q <= bus.A;
               end
            end
            CALC: begin
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) state <= FIX;
            end
            FIX: begin
               if (div_q) begin
                  if (div0) begin
                     hi_q <= orig_a;
                     lo_q <= DIV0_Q;
                  end else begin
                     hi_q <= rem_fix;
                     lo_q <= quo_fix;
                  end
               end else begin
                  {hi_q, lo_q} <= prod_fix;
               end
               done_q <= 1'b1;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected {hi,lo}; a
// negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   muldiv_unit_if #(.WIDTH(32)) bus();

   muldiv_unit #(.WIDTH(32), .DIV0_Q(32'hFFFF_FFFF)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   int          done_cnt = 0;
   int          busy_run = 0;
   logic        done_prev = 1'b0;
   logic [63:0] sb[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: results on done, done/busy exclusivity, busy length per op.
   always @(negedge clk) begin
      if (rst) begin
         busy_run  = 0;
         done_prev = 1'b0;
         sb.delete();
      end else begin
         if (bus.done) begin
            logic [63:0] exp;
            done_cnt++;
            check("done_not_busy", 64'(bus.busy), 64'd0);
            check("done_one_cycle", 64'(done_prev), 64'd0);
            check("sb_pending", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               exp = sb.pop_front();
               check("hi_lo_result", {bus.hi, bus.lo}, exp);
            end
         end
         if (bus.busy) busy_run++;
         else if (busy_run != 0) begin
            check("busy_cycles", 64'(busy_run), 64'd33);
            busy_run = 0;
         end
         done_prev = bus.done;
      end
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic exp_valid, input logic [63:0] exp);
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.op    = op;
      bus.A     = a;
      bus.B     = b;
      if (exp_valid) sb.push_back(exp);
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.op    = MD_NOP;
   endtask

   task automatic wait_done(input string name);
      int c0;
      c0 = done_cnt;
      for (int i = 0; i < 60 && done_cnt == c0; i++) @(posedge clk);
      check(name, 64'(done_cnt), 64'(c0 + 1));
   endtask

   initial begin
      bus.start = 1'b0;
      bus.op    = MD_NOP;
      bus.A     = '0;
      bus.B     = '0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 64'(bus.busy), 64'd0);
      check("reset_done", 64'(bus.done), 64'd0);
      check("reset_hi", 64'(bus.hi), 64'd0);
      check("reset_lo", 64'(bus.lo), 64'd0);
      #1 rst = 1'b0;

      issue(MD_MULT,  32'hFFFF_FFFD, 32'd7,         1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
      wait_done("done_mult_neg");
      issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
      wait_done("done_multu_max");
      issue(MD_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000);
      wait_done("done_mult_extreme");
      issue(MD_DIV,   32'hFFFF_FFF9, 32'd2,         1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
      wait_done("done_div_neg_dividend");
      issue(MD_DIV,   32'd7,         32'hFFFF_FFFE, 1'b1, 64'h0000_0001_FFFF_FFFD);
      wait_done("done_div_neg_divisor");
      issue(MD_DIVU,  32'd7,         32'd2,         1'b1, 64'h0000_0001_0000_0003);
      wait_done("done_divu");
      issue(MD_DIVU,  32'd5,         32'd0,         1'b1, 64'h0000_0005_FFFF_FFFF);
      wait_done("done_divu_zero");
      issue(MD_DIV,   32'hFFFF_FFFB, 32'd0,         1'b1, 64'hFFFF_FFFB_FFFF_FFFF);
      wait_done("done_div_zero_signed");
      issue(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000);
      wait_done("done_div_overflow");
      issue(MD_DIV,   32'd7,         32'hFFFF_FFFE, 1'b1, 64'h0000_0001_FFFF_FFFD);
      wait_done("done_div_reload");

      // Register moves: immediate, no busy/done.
      issue(MD_MTHI, 32'h1234_5678, 32'd0, 1'b0, 64'd0);
      check("mthi_hi", 64'(bus.hi), 64'h1234_5678);
      check("mthi_lo_kept", 64'(bus.lo), 64'hFFFF_FFFD);
      check("mthi_busy", 64'(bus.busy), 64'd0);
      check("mthi_done", 64'(bus.done), 64'd0);
      issue(MD_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0, 64'd0);
      check("mtlo_lo", 64'(bus.lo), 64'hCAFE_F00D);
      check("mtlo_hi_kept", 64'(bus.hi), 64'h1234_5678);
      issue(3'b111, 32'hDEAD_BEEF, 32'd1, 1'b0, 64'd0);
      check("undef_op_hilo", {bus.hi, bus.lo}, 64'h1234_5678_CAFE_F00D);
      check("undef_op_busy", 64'(bus.busy), 64'd0);

      // MTLO while busy is ignored; hi/lo hold until the FIX edge.
      issue(MD_MULT, 32'd3, 32'hFFFF_FFFC, 1'b1, 64'hFFFF_FFFF_FFFF_FFF4);
      repeat (2) @(posedge clk);
      issue(MD_MTLO, 32'h5555_AAAA, 32'd0, 1'b0, 64'd0);
      check("busy_during_mult", 64'(bus.busy), 64'd1);
      check("hold_during_mult", {bus.hi, bus.lo}, 64'h1234_5678_CAFE_F00D);
      wait_done("done_mult_ignore_mtlo");

      // Asynchronous reset mid-divide, then a fresh multiply.
      issue(MD_DIV, 32'd100, 32'd7, 1'b1, 64'h0000_0002_0000_000E);
      repeat (8) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("async_rst_busy", 64'(bus.busy), 64'd0);
      check("async_rst_done", 64'(bus.done), 64'd0);
      check("async_rst_hilo", {bus.hi, bus.lo}, 64'd0);
      #12 rst = 1'b0;
      issue(MD_MULTU, 32'd3, 32'd4, 1'b1, 64'h0000_0000_0000_000C);
      wait_done("done_multu_after_rst");

      repeat (3) @(posedge clk);
      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
- Sits in the execute stage beside the ALU and takes the same A/B operand buses.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- HI/LO outputs feed the MFHI/MFLO leg of the execute result mux; `busy` feeds the hazard unit for stalling.

Parameters:
- WIDTH, 32, operand and HI/LO width; only 32 is supported.
- DIV0_Q, 32'hFFFF_FFFF, value written to LO on divide-by-zero.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  operation request, qualified by op; sampled only in IDLE.
- op  in  3  operation code; encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU/MD_MTHI/MD_MTLO.
- A  in  32  operand (multiplicand/dividend/MT source).
- B  in  32  operand (multiplier/divisor).
- busy  out  1  high while a mul/div is in flight.
- done  out  1  one-cycle pulse when HI/LO are updated by a mul/div.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (async, any time, including mid-operation):
  - hi=lo=0, busy=0, done=0, state=IDLE, counter=0.
  - Any in-flight operation is discarded.
- States:
  - IDLE -> CALC on start with op in {MULT, MULTU, DIV, DIVU}.
  - CALC -> FIX after 32 iterations.
  - FIX -> IDLE unconditionally.
- IDLE, accept edge:
  - For signed ops, latch sign flags and |A|, |B|; for unsigned ops, latch A and B raw.
  - Clear the 64-bit accumulator and the 5-bit counter; busy=1 from the next cycle.
- IDLE, MTHI/MTLO:
  - start with MTHI writes hi=A at that edge; MTLO writes lo=A.
  - No busy, no done.
  - Undefined op codes are ignored.
- CALC, one iteration per edge, 32 edges:
  - Multiply: shift-add, 64-bit product.
  - Divide: restoring, 1 quotient bit per edge, 33-bit partial remainder.
- FIX (1 edge):
  - Apply sign correction and write hi/lo. done=1 for exactly the following cycle; busy=0 from the following cycle.
  - Multiply: {hi,lo} = product, negated if signs differ.
  - Divide: lo = quotient, negated if signs differ; hi = remainder, with the sign of the dividend.
- Latency:
  - Accept edge E0, iterations E1..E32, write at E33.
  - busy is high for exactly 33 cycles; hi/lo are valid in the cycle after E33, coincident with done.
- Divide by zero (B==0, signed or unsigned):
  - Same 33-cycle timing.
  - lo=DIV0_Q, hi=A (original, unmodified).
- Signed overflow (DIV 0x8000_0000 / 0xFFFF_FFFF): lo=0x8000_0000, hi=0. Falls out of the abs/negate path; no special case.
- While busy:
  - start (any op, including MTHI/MTLO) is ignored; the hazard unit stalls.
  - hi/lo hold their old values until the FIX edge.
- hi/lo change only at the FIX edge, on MTHI/MTLO, or on reset.
- done never overlaps busy.

Decomposition:
- Add MD_* op encodings to the shared ctrl_encode_def constants: MD_NOP=3'b000, MD_MULT=3'b001, MD_MULTU=3'b010, MD_DIV=3'b011, MD_DIVU=3'b100, MD_MTHI=3'b101, MD_MTLO=3'b110.
- Add state encodings (IDLE/CALC/FIX) to the same constants file.
- Top level holds the FSM, counter, HI/LO and sign-fix logic.
- One sub-module, md_iter_core: holds the accumulator and performs one shift-add or restore-subtract step per enable.

Test Plan:
- MULT A=0xFFFF_FFFD (-3), B=7 -> after E33: hi=0xFFFF_FFFF, lo=0xFFFF_FFEB; busy high 33 cycles; done pulses once.
- MULTU A=B=0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001.
- DIV A=0xFFFF_FFF9 (-7), B=2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIVU A=7, B=2 -> lo=3, hi=1.
- DIVU A=5, B=0 -> lo=0xFFFF_FFFF, hi=5, same 33-cycle timing. DIV A=0x8000_0000, B=0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
- MTHI A=0x1234_5678 in IDLE -> hi=0x1234_5678 next cycle, busy/done stay 0. MTLO issued at cycle 5 of a MULT -> ignored; final lo equals the product.
- rst asserted asynchronously at cycle 10 of a DIV -> immediately busy=0, done=0, hi=lo=0. A new MULTU 3x4 afterwards -> lo=12, hi=0.
